// File: rtl/tl_beat_tracker.sv
// Passive beat counter on the arbiter output; last/first/beat_idx are combinational (0 cycles), state and errors 1 cycle.
// Never backpressures: only observes valid_i/ready_i, and outputs never depend on ready_i so they hold steady under stalls.
module tl_beat_tracker #(
    parameter int          DATA_W        = 100,
    parameter int          OPC_LSB       = 0,
    parameter int          SIZE_LSB      = 3,
    parameter int          SIZE_W        = 4,
    parameter int          BEAT_BYTES    = 8,
    parameter int          MAX_BEATS     = 8,
    parameter logic [7:0]  HAS_DATA_MASK = 8'h0F,
    localparam int         BEAT_W        = $clog2(MAX_BEATS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              last_o,
    output logic              first_o,
    output logic [BEAT_W-1:0] beat_idx_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    input  logic              err_clr_i
);

    localparam int               BB_LOG    = $clog2(BEAT_BYTES);
    localparam logic [SIZE_W:0]  SZ_ONE    = (SIZE_W+1)'(BB_LOG);
    localparam logic [SIZE_W:0]  SZ_MAX    = (SIZE_W+1)'(BB_LOG + BEAT_W);
    localparam logic [BEAT_W:0]  BEATS_ONE = (BEAT_W+1)'(1);
    localparam logic [BEAT_W:0]  BEATS_MAX = (BEAT_W+1)'(MAX_BEATS);
    localparam logic [1:0]       ERR_NONE  = 2'd0;
    localparam logic [1:0]       ERR_OVSZ  = 2'd1;
    localparam logic [1:0]       ERR_OPC   = 2'd2;
    localparam logic [1:0]       ERR_SIZE  = 2'd3;

    logic              in_burst_q, in_burst_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [BEAT_W:0]   total_q, total_d;
    logic [2:0]        opc_q, opc_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic [2:0]        opc;
    logic [SIZE_W-1:0] size;
    logic [SIZE_W:0]   size_ext;
    logic [BEAT_W:0]   beats;
    logic              oversize;
    logic              fire;
    logic [1:0]        new_err;
    logic              unused_data;

    assign opc         = data_i[OPC_LSB +: 3];
    assign size        = data_i[SIZE_LSB +: SIZE_W];
    assign size_ext    = {1'b0, size};
    assign fire        = valid_i & ready_i;
    assign unused_data = ^data_i;

    // Range-check the shift amount first so 2^size never has to be formed.
    always_comb begin
        beats    = BEATS_ONE;
        oversize = 1'b0;
        if (HAS_DATA_MASK[opc]) begin
            if (size_ext > SZ_MAX) begin
                oversize = 1'b1;
                beats    = BEATS_MAX;
            end else if (size_ext > SZ_ONE) begin
                beats = BEATS_ONE << (size_ext - SZ_ONE);
            end
        end
    end

    assign first_o    = ~in_burst_q;
    assign beat_idx_o = in_burst_q ? cnt_q : '0;
    assign last_o     = in_burst_q ? ({1'b0, cnt_q} == total_q - BEATS_ONE)
                                   : (beats == BEATS_ONE);

    always_comb begin
        in_burst_d = in_burst_q;
        cnt_d      = cnt_q;
        total_d    = total_q;
        opc_d      = opc_q;
        size_d     = size_q;
        new_err    = ERR_NONE;
        if (fire) begin
            if (!in_burst_q) begin
                if (oversize) new_err = ERR_OVSZ;
                if (beats != BEATS_ONE) begin
                    in_burst_d = 1'b1;
                    cnt_d      = BEAT_W'(1);
                    total_d    = beats;
                    opc_d      = opc;
                    size_d     = size;
                end
            end else begin
                if (opc != opc_q)        new_err = ERR_OPC;
                else if (size != size_q) new_err = ERR_SIZE;
                if (last_o) begin
                    in_burst_d = 1'b0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Only the first error is kept; a clear in the same cycle lets the new one in.
    always_comb begin
        err_d  = err_q;
        code_d = code_q;
        if (err_clr_i) begin
            err_d  = 1'b0;
            code_d = ERR_NONE;
        end
        if (new_err != ERR_NONE && (!err_q || err_clr_i)) begin
            err_d  = 1'b1;
            code_d = new_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_burst_q <= 1'b0;
            cnt_q      <= '0;
            total_q    <= '0;
            opc_q      <= '0;
            size_q     <= '0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
        end else begin
            in_burst_q <= in_burst_d;
            cnt_q      <= cnt_d;
            total_q    <= total_d;
            opc_q      <= opc_d;
            size_q     <= size_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign err_o      = err_q;
    assign err_code_o = code_q;

endmodule

// File: tb/tb_tl_beat_tracker.sv
// Directed bench for tl_beat_tracker: per-cycle comparison against a message-level model plus literal spot checks.
module tb_tl_beat_tracker;

    localparam int DATA_W = 100;
    localparam int BB     = 8;
    localparam int MB     = 8;
    localparam logic [7:0] MASK = 8'h0F;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid = 1'b0;
    logic              ready = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              err_clr = 1'b0;
    logic              last_o, first_o, err_o;
    logic [2:0]        beat_idx_o;
    logic [1:0]        err_code_o;

    int tests = 0;
    int fails = 0;

    // Message-level model state
    bit m_in;
    int m_idx, m_total, m_opc, m_size;
    bit m_err;
    int m_code;

    tl_beat_tracker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_i    (valid),
        .ready_i    (ready),
        .data_i     (data),
        .last_o     (last_o),
        .first_o    (first_o),
        .beat_idx_o (beat_idx_o),
        .err_o      (err_o),
        .err_code_o (err_code_o),
        .err_clr_i  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Checks outputs against the model, then advances the model for the coming edge.
    always @(negedge clk) begin
        int opc, sz, b, e;
        bit over, exp_first, exp_last;
        int exp_idx;
        if (!rst_n) begin
            m_in = 0; m_idx = 0; m_total = 0; m_opc = 0; m_size = 0;
            m_err = 0; m_code = 0;
        end
        opc  = int'(data[2:0]);
        sz   = int'(data[6:3]);
        over = 0;
        if (!MASK[opc]) begin
            b = 1;
        end else begin
            b = (1 << sz) / BB;
            if (b < 1) b = 1;
            if (b > MB) begin
                over = 1;
                b = MB;
            end
        end
        if (!m_in) begin
            exp_first = 1; exp_idx = 0; exp_last = (b == 1);
        end else begin
            exp_first = 0; exp_idx = m_idx; exp_last = (m_idx == m_total - 1);
        end
        chk("model_first", 32'(first_o), 32'(exp_first));
        chk("model_idx",   32'(beat_idx_o), 32'(exp_idx));
        chk("model_last",  32'(last_o), 32'(exp_last));
        chk("model_err",   32'(err_o), 32'(m_err));
        chk("model_code",  32'(err_code_o), 32'(m_code));
        if (rst_n) begin
            e = 0;
            if (valid && ready) begin
                if (!m_in) begin
                    if (over) e = 1;
                    if (b > 1) begin
                        m_in = 1; m_idx = 1; m_total = b; m_opc = opc; m_size = sz;
                    end
                end else begin
                    if (opc != m_opc)      e = 2;
                    else if (sz != m_size) e = 3;
                    if (exp_last) begin
                        m_in = 0; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
            if (err_clr) begin
                m_err = 0; m_code = 0;
            end
            if (e != 0 && !m_err) begin
                m_err = 1; m_code = e;
            end
        end
    end

    // Drives one cycle of inputs just after the rising edge, then waits briefly for literal checks.
    task automatic drv(input bit v, input bit r, input int opc, input int sz, input bit clr);
        logic [DATA_W-1:0] d;
        @(posedge clk);
        #1;
        d = DATA_W'({$urandom(), $urandom(), $urandom(), $urandom()});
        d[2:0] = 3'(opc);
        d[6:3] = 4'(sz);
        valid   = v;
        ready   = r;
        data    = d;
        err_clr = clr;
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_err",   32'(err_o), 0);
        chk("rst_code",  32'(err_code_o), 0);
        chk("rst_first", 32'(first_o), 1);
        chk("rst_idx",   32'(beat_idx_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Get, size 6: single beat
        drv(1, 1, 4, 6, 0);
        chk("get_last",  32'(last_o), 1);
        chk("get_first", 32'(first_o), 1);
        chk("get_idx",   32'(beat_idx_o), 0);
        drv(0, 1, 0, 6, 0);
        chk("get_idle",  32'(first_o), 1);

        // PutFullData size 6: 8 beats back to back
        for (int i = 0; i < 8; i++) begin
            drv(1, 1, 0, 6, 0);
            chk("put_idx",   32'(beat_idx_o), 32'(i));
            chk("put_last",  32'(last_o), 32'(i == 7));
            chk("put_first", 32'(first_o), 32'(i == 0));
        end
        drv(0, 0, 4, 0, 0);
        chk("put_after", 32'(first_o), 1);

        // Same burst with backpressure at idx 3 and a valid gap at idx 5
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                for (int k = 0; k < 3; k++) begin
                    drv(1, 0, 0, 6, 0);
                    chk("stall_idx",  32'(beat_idx_o), 3);
                    chk("stall_last", 32'(last_o), 0);
                end
            end
            if (i == 5) begin
                for (int k = 0; k < 2; k++) begin
                    drv(0, 1, 0, 6, 0);
                    chk("gap_idx", 32'(beat_idx_o), 5);
                end
            end
            drv(1, 1, 0, 6, 0);
            chk("stl_idx",  32'(beat_idx_o), 32'(i));
            chk("stl_last", 32'(last_o), 32'(i == 7));
        end

        // PutFull size 2: one beat. PutFull size 7: clamped to 8 with oversize error.
        drv(1, 1, 0, 2, 0);
        chk("small_last", 32'(last_o), 1);
        for (int i = 0; i < 8; i++) begin
            drv(1, 1, 0, 7, 0);
            if (i == 1) begin
                chk("ovsz_err",  32'(err_o), 1);
                chk("ovsz_code", 32'(err_code_o), 1);
            end
            chk("ovsz_last", 32'(last_o), 32'(i == 7));
        end
        drv(0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0);
        chk("clr1_err", 32'(err_o), 0);

        // 4-beat burst with opcode change on beat 2
        drv(1, 1, 0, 5, 0);
        chk("opc_b0_last", 32'(last_o), 0);
        drv(1, 1, 0, 5, 0);
        drv(1, 1, 1, 5, 0);
        chk("opc_b2_idx", 32'(beat_idx_o), 2);
        drv(1, 1, 0, 5, 0);
        chk("opc_b3_last", 32'(last_o), 1);
        chk("opc_err",     32'(err_o), 1);
        chk("opc_code",    32'(err_code_o), 2);
        drv(0, 1, 0, 0, 1);
        drv(0, 0, 0, 0, 0);
        chk("clr2_err",  32'(err_o), 0);
        chk("clr2_code", 32'(err_code_o), 0);

        // Size change, then clear colliding with opcode+size change: new code 2 wins
        drv(1, 1, 0, 5, 0);
        drv(1, 1, 0, 4, 0);
        drv(1, 1, 1, 4, 1);
        chk("sz_code", 32'(err_code_o), 3);
        drv(1, 1, 0, 5, 0);
        chk("clrwin_err",  32'(err_o), 1);
        chk("clrwin_code", 32'(err_code_o), 2);
        chk("clrwin_last", 32'(last_o), 1);
        // Oversize while an error is held must not overwrite the code
        for (int i = 0; i < 8; i++) drv(1, 1, 0, 9, 0);
        drv(0, 0, 0, 0, 0);
        chk("hold_code", 32'(err_code_o), 2);
        drv(0, 0, 0, 0, 1);

        // Async reset mid-burst
        drv(1, 1, 0, 6, 0);
        drv(1, 1, 0, 5, 0);
        drv(1, 0, 0, 6, 0);
        chk("prerst_idx", 32'(beat_idx_o), 2);
        chk("prerst_err", 32'(err_o), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_first", 32'(first_o), 1);
        chk("rst_async_err",   32'(err_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drv(1, 1, 0, 6, 0);
        chk("postrst_first", 32'(first_o), 1);
        chk("postrst_idx",   32'(beat_idx_o), 0);
        chk("postrst_err",   32'(err_o), 0);
        for (int i = 1; i < 8; i++) drv(1, 1, 0, 6, 0);
        drv(0, 0, 0, 0, 0);
        chk("postrst_idle", 32'(first_o), 1);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tl_beat_tracker.md
Name: tl_beat_tracker

Overview:
- Passive monitor on the single-sink output of the crossbar channel arbiter.
- Decodes opcode/size of each granted message, counts handshaken beats and drives the combinational `last_o` that the arbiter consumes as its burst-lock input.
- Also exports first-beat and beat-index strobes for downstream sinks, plus a sticky protocol-error flag.
- Never stalls traffic: no ready/valid of its own.

Parameters:
- DATA_W, 100, width of the flattened channel payload.
- OPC_LSB, 0, bit position of the 3-bit opcode field in data_i.
- SIZE_LSB, 3, bit position of the size field (log2 bytes) in data_i.
- SIZE_W, 4, width of the size field.
- BEAT_BYTES, 8, bytes per beat; power of two, 1 to 64.
- MAX_BEATS, 8, maximum legal beats per message; power of two, 2 or more.
- HAS_DATA_MASK, 8'h0F, bit k set means opcode k carries data. Default is the A-channel Put/Arith/Logic set; the D-channel instance uses 8'h22.
- BEAT_W (localparam), clog2(MAX_BEATS), counter width.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: asynchronous, active-low.
- valid_i, input, 1, arbiter output valid (observed).
- ready_i, input, 1, sink ready (observed).
- data_i, input, DATA_W, arbiter output payload (observed).
- last_o, output, 1, current beat is final beat of message (combinational).
- first_o, output, 1, current beat is first beat of message (combinational).
- beat_idx_o, output, BEAT_W, index of current beat within message (combinational).
- err_o, output, 1, sticky protocol error.
- err_code_o, output, 2, code of the first error captured: 1 = oversize, 2 = opcode changed mid-burst, 3 = size changed mid-burst.
- err_clr_i, input, 1, synchronous clear of err_o and err_code_o.

Behaviour:
- Fire is defined as valid_i && ready_i. All state updates happen only on fire.
- State registers: in_burst_q, cnt_q[BEAT_W-1:0], total_q[BEAT_W:0], opc_q, size_q.
- Reset values: in_burst_q=0, cnt_q=0, total_q=0, err_o=0, err_code_o=0. Outputs from reset are therefore last_o per decode, first_o=1, beat_idx_o=0.
- Beat decode (combinational, from current data_i):
  - If HAS_DATA_MASK[opcode]=0, beats = 1.
  - Otherwise beats = max(1, 2^size / BEAT_BYTES).
  - If beats > MAX_BEATS, set beats = MAX_BEATS and raise an oversize error on fire.
  - Arithmetic must not overflow for size up to 2^SIZE_W-1; compare the shift amount, not the shifted value.
- IDLE (in_burst_q=0):
  - first_o=1, beat_idx_o=0, last_o = (beats==1).
  - On fire with beats==1: stay in IDLE.
  - On fire with beats>1: go to BURST; cnt_q=1, total_q=beats, opc_q and size_q latch data_i.
- BURST (in_burst_q=1):
  - first_o=0, beat_idx_o=cnt_q, last_o = (cnt_q == total_q-1).
  - Decode of the current data_i is ignored for the length; the latched total is authoritative.
  - On fire: if last_o, return to IDLE with cnt_q=0; otherwise cnt_q+1.
  - On fire, an opcode differing from opc_q raises code 2, and a size differing from size_q raises code 3. The burst still completes on the latched count.
- last_o, first_o and beat_idx_o depend only on data_i and state, never on ready_i. This keeps them stable while valid_i is held under backpressure and avoids a comb loop through the arbiter.
- valid_i high without ready_i: no state change.
- valid_i low during BURST: state held. Gaps between beats are legal.
- Error register:
  - err_o sets on the first error and holds.
  - err_code_o records only the first error; later errors do not overwrite it.
  - If err_clr_i and a new error occur in the same cycle, the new error wins (err_o=1 with the new code).
  - When several errors occur on the same beat, code 2 has priority over 3; code 1 occurs only in IDLE.
- Asynchronous reset mid-burst returns to IDLE immediately, so the next fire is treated as a first beat.
- Latency: zero cycles for the combinational outputs; one cycle for state and err_o.

Test Plan:
- Get (opcode 4), size 6, single fire → last_o=1, first_o=1, beat_idx_o=0, state stays IDLE.
- PutFullData (opcode 0), size 6, BEAT_BYTES=8, 8 consecutive fires → beat_idx_o 0..7; last_o=1 only on idx 7; first_o=1 only on idx 0; IDLE afterwards.
- Same 8-beat Put with ready_i low for 3 cycles at idx 3 and valid_i low for 2 cycles at idx 5 → last_o/beat_idx_o stable through stalls; last_o still lands on the 8th fire.
- PutFull size 2 → 1 beat, last_o=1. PutFull size 7 with MAX_BEATS=8 → clamped to 8 beats, err_o=1 and err_code_o=1 one cycle after the first fire.
- Burst of 4 where beat 2 carries opcode 1 → err_code_o=2, burst ends on beat 3. Then assert err_clr_i → err_o=0 the next cycle.
- Assert rst_n=0 at idx 2 of an 8-beat burst, then release → the next fire shows first_o=1, beat_idx_o=0, and err_o=0.
